// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Width of a counter that must hold values 0..n-1.
    function automatic int unsigned clog2_cnt(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= UART_IDLE_LVL;
            q_o    <= UART_IDLE_LVL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive framer: start detection, mid-bit sampling, LSB-first word assembly.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic [2:0]           bit_idx_o,
    output logic                 busy_o
);

    localparam int unsigned     CNT_W    = clog2_cnt(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    uart_rx_state_t       state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [DATA_BITS-1:0] shift_r;
    logic                 rx_s;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            shift_r     <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            bit_idx_o   <= '0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            clk_cnt     <= clk_cnt + CNT_W'(1);
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_s != UART_IDLE_LVL) state <= START;
                end
                START: begin
                    // Re-check at mid start bit so short glitches are rejected.
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        state   <= (rx_s == UART_IDLE_LVL) ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_MAX) begin
                        clk_cnt <= '0;
                        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_idx_o == LAST_IDX) begin
                            bit_idx_o <= '0;
                            state     <= STOP;
                        end else begin
                            bit_idx_o <= bit_idx_o + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_MAX) begin
                        clk_cnt <= '0;
                        if (rx_s == UART_IDLE_LVL) begin
                            data_o  <= shift_r;
                            valid_o <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold here until the line returns idle so a stuck-low line cannot retrigger.
                    clk_cnt <= '0;
                    if (rx_s == UART_IDLE_LVL) state <= IDLE;
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with 16 clocks per bit and 8 data bits.
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic [2:0] bit_idx_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int start_cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int t_valid = 0;
    int t_valid_prev = 0;
    int t_err = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    logic both_seen = 1'b0;
    logic wide_seen = 1'b0;
    logic idx_bad = 1'b0;

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .bit_idx_o   (bit_idx_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        prev_valid <= valid_o;
        prev_err   <= frame_err_o;
        if (valid_o) begin
            n_valid      <= n_valid + 1;
            t_valid_prev <= t_valid;
            t_valid      <= cyc;
            prev_data    <= last_data;
            last_data    <= data_o;
        end
        if (frame_err_o) begin
            n_err <= n_err + 1;
            t_err <= cyc;
        end
        if (valid_o && frame_err_o) both_seen <= 1'b1;
        if ((valid_o && prev_valid) || (frame_err_o && prev_err)) wide_seen <= 1'b1;
        if (!busy_o && bit_idx_o != 3'd0) idx_bad <= 1'b1;
    end

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
        checks++; if (bit_idx_o !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", bit_idx_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_single_frame();
        int nv0, ne0, lat;
        nv0 = n_valid;
        ne0 = n_err;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        lat = t_valid - start_cyc;
        checks++; if (n_valid - nv0 !== 1) begin errors++; $display("FAIL a5_count got=%0d exp=1", n_valid - nv0); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", data_o); end
        checks++; if (n_err !== ne0) begin errors++; $display("FAIL a5_ferr got=%0d exp=%0d", n_err, ne0); end
        checks++; if (lat < 154 || lat > 156) begin errors++; $display("FAIL a5_latency got=%0d exp=154..156", lat); end
    endtask

    task automatic test_back_to_back();
        int nv0;
        nv0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (n_valid - nv0 !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", n_valid - nv0); end
        checks++; if (prev_data !== 8'h00) begin errors++; $display("FAIL b2b_first got=%h exp=00", prev_data); end
        checks++; if (last_data !== 8'hFF) begin errors++; $display("FAIL b2b_second got=%h exp=ff", last_data); end
        checks++; if (t_valid - t_valid_prev !== 160) begin errors++; $display("FAIL b2b_spacing got=%0d exp=160", t_valid - t_valid_prev); end
    endtask

    task automatic test_glitch();
        int nv0, ne0, waited;
        nv0 = n_valid;
        ne0 = n_err;
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_on got=%b exp=1", busy_o); end
        @(negedge clk);
        rx_i = 1'b1;
        waited = 0;
        while (busy_o && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_off got=%b exp=0 within 10", busy_o); end
        repeat (CPB * 2) @(negedge clk);
        checks++; if (n_valid !== nv0 || n_err !== ne0) begin
            errors++; $display("FAIL glitch_strobes got=%0d/%0d exp=%0d/%0d", n_valid, n_err, nv0, ne0);
        end
    endtask

    task automatic test_frame_error();
        int nv0, ne0, lat;
        nv0 = n_valid;
        ne0 = n_err;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        lat = t_err - start_cyc;
        checks++; if (n_err - ne0 !== 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", n_err - ne0); end
        checks++; if (n_valid !== nv0) begin errors++; $display("FAIL ferr_novalid got=%0d exp=%0d", n_valid, nv0); end
        checks++; if (data_o !== 8'hFF) begin errors++; $display("FAIL ferr_data_kept got=%h exp=ff", data_o); end
        checks++; if (lat < 154 || lat > 156) begin errors++; $display("FAIL ferr_latency got=%0d exp=154..156", lat); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ferr_break_hold got=%b exp=1", busy_o); end
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got=%b exp=0", busy_o); end
        send_frame(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (n_valid - nv0 !== 1 || data_o !== 8'h81) begin
            errors++; $display("FAIL ferr_recover got=%h/%0d exp=81/1", data_o, n_valid - nv0);
        end
    endtask

    task automatic test_mid_reset();
        int nv0, ne0;
        logic [7:0] d;
        d = 8'hF3;
        nv0 = n_valid;
        ne0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_i = d[4];
        repeat (CPB / 2) @(negedge clk);
        checks++; if (bit_idx_o !== 3'd4) begin errors++; $display("FAIL rst_pre_idx got=%0d exp=4", bit_idx_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0 || bit_idx_o !== 3'd0) begin
            errors++; $display("FAIL rst_state got=busy%b/idx%0d exp=busy0/idx0", busy_o, bit_idx_o);
        end
        checks++; if (data_o !== 8'h00 || valid_o !== 1'b0 || frame_err_o !== 1'b0) begin
            errors++; $display("FAIL rst_outputs got=%h/%b/%b exp=00/0/0", data_o, valid_o, frame_err_o);
        end
        rx_i = 1'b1;
        repeat (CPB * 5) @(negedge clk);
        checks++; if (n_valid !== nv0 || n_err !== ne0) begin
            errors++; $display("FAIL rst_no_strobe got=%0d/%0d exp=%0d/%0d", n_valid, n_err, nv0, ne0);
        end
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (n_valid - nv0 !== 1 || data_o !== 8'h5A) begin
            errors++; $display("FAIL rst_recover got=%h/%0d exp=5a/1", data_o, n_valid - nv0);
        end
    endtask

    task automatic test_bit_idx();
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (5) @(negedge clk);
                checks++; if (bit_idx_o !== 3'd0 || busy_o !== 1'b1) begin
                    errors++; $display("FAIL idx_start got=%0d/%b exp=0/1", bit_idx_o, busy_o);
                end
                repeat (13) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    checks++; if (bit_idx_o !== 3'(k)) begin
                        errors++; $display("FAIL idx_data%0d got=%0d exp=%0d", k, bit_idx_o, k);
                    end
                    repeat (CPB) @(negedge clk);
                end
                checks++; if (bit_idx_o !== 3'd0 || busy_o !== 1'b1) begin
                    errors++; $display("FAIL idx_stop got=%0d/%b exp=0/1", bit_idx_o, busy_o);
                end
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (data_o !== 8'h96) begin errors++; $display("FAIL idx_data got=%h exp=96", data_o); end
    endtask

    task automatic test_monitors();
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL mon_both got=%b exp=0", both_seen); end
        checks++; if (wide_seen !== 1'b0) begin errors++; $display("FAIL mon_wide got=%b exp=0", wide_seen); end
        checks++; if (idx_bad !== 1'b0) begin errors++; $display("FAIL mon_idx_idle got=%b exp=0", idx_bad); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_mid_reset();
        test_bit_idx();
        test_monitors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
